aes_axis_slave: RTL and testbench

- AXI4-Stream slave front-end of the AES engine.
- Receives 32-bit beats from the DMA: the first beat is the command word, and the remaining beats are packed into 128-bit blocks and written into the input FIFO.
- Holds the command for the downstream AES controller and signals end-of-transfer via axis_slave_done.
- Re-arms for the next transfer on the controller's processing_done.

---
 rtl/aes_axis_slave_pkg.sv | 18 +
 rtl/aes_axis_slave_if.sv | 23 ++
 rtl/aes_axis_slave_word_packer.sv | 48 ++++
 rtl/aes_axis_slave.sv | 126 ++++++++++++
 tb/tb_aes_axis_slave.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_axis_slave_pkg.sv
// Shared widths and FSM state type for the AES stream slave front-end.
package aes_axis_slave_pkg;

   localparam int unsigned WORD_S        = 32;
   localparam int unsigned BLK_S         = 128;
   localparam int unsigned WORDS_PER_BLK = BLK_S / WORD_S;
   localparam int unsigned IDX_W         = $clog2(WORDS_PER_BLK);
   localparam int unsigned CNT_W         = 16;

   // The command word is carried through opaquely; no field decode happens here.
   typedef enum logic [1:0] {
      StIdle,
      StData,
      StPush,
      StDone
   } state_t;

endpackage

// File: rtl/aes_axis_slave_if.sv
// Stream-in and FIFO-out handshake bundle of the AES stream slave.
interface aes_axis_slave_if;
   import aes_axis_slave_pkg::*;

   logic [WORD_S-1:0] s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic              s_axis_tlast;
   logic [BLK_S-1:0]  fifo_write_tdata;
   logic              fifo_write_tvalid;
   logic              fifo_write_tready;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, fifo_write_tready,
      output s_axis_tready, fifo_write_tdata, fifo_write_tvalid
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, fifo_write_tready,
      input  s_axis_tready, fifo_write_tdata, fifo_write_tvalid
   );

endinterface

// File: rtl/aes_axis_slave_word_packer.sv
// Packs 32-bit words MSW-first into a 128-bit block; unfilled words stay zero.
module aes_axis_slave_word_packer
   import aes_axis_slave_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [WORD_S-1:0] wr_data,
   output logic              block_ready,
   output logic [BLK_S-1:0]  block
);

   localparam logic [IDX_W-1:0] IdxLast = IDX_W'(WORDS_PER_BLK - 1);

   logic [BLK_S-1:0] blk_q, blk_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   // The buffer is zero at every block start, so OR-ing the shifted word both
   // places it and leaves the lower slots zero-padded on an early flush.
   always_comb begin
      blk_d = blk_q;
      idx_d = idx_q;
      if (clear) begin
         blk_d = '0;
         idx_d = '0;
      end else if (wr_en) begin
         blk_d = blk_q | ({wr_data, {(BLK_S - WORD_S){1'b0}}} >> (idx_q * WORD_S));
         idx_d = idx_q + IDX_W'(1);
      end
   end

   // Buffer and word index registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         blk_q <= '0;
         idx_q <= '0;
      end else begin
         blk_q <= blk_d;
         idx_q <= idx_d;
      end
   end

   // High when the next written word completes the block.
   assign block_ready = (idx_q == IdxLast);
   assign block       = blk_q;

endmodule

// File: rtl/aes_axis_slave.sv
// AXI4-Stream slave: latches the command beat, packs data beats into blocks
// for the input FIFO, and flags end-of-transfer until the controller re-arms it.
module aes_axis_slave
   import aes_axis_slave_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   aes_axis_slave_if.slave   bus,
   output logic [WORD_S-1:0] aes_cmd,
   output logic              axis_slave_done,
   input  logic              processing_done,
   output logic [CNT_W-1:0]  blk_count
);

   state_t            state_q, state_d;
   logic [WORD_S-1:0] cmd_q, cmd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              ready_q, ready_d;
   logic              accept, pushed;
   logic              pk_clear, pk_wr, pk_block_ready;
   logic [BLK_S-1:0]  pk_block;

   aes_axis_slave_word_packer u_packer (
      .clk         (clk),
      .reset       (reset),
      .clear       (pk_clear),
      .wr_en       (pk_wr),
      .wr_data     (bus.s_axis_tdata),
      .block_ready (pk_block_ready),
      .block       (pk_block)
   );

   // Next-state and handshake decisions for the transfer FSM.
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      valid_d  = valid_q;
      done_d   = done_q;
      pk_clear = 1'b0;
      pk_wr    = 1'b0;
      accept   = bus.s_axis_tvalid && ready_q;
      pushed   = valid_q && bus.fifo_write_tready;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               cmd_d    = bus.s_axis_tdata;
               cnt_d    = '0;
               pk_clear = 1'b1;
               if (bus.s_axis_tlast) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               pk_wr = 1'b1;
               if (pk_block_ready || bus.s_axis_tlast) begin
                  state_d = StPush;
                  valid_d = 1'b1;
                  last_d  = bus.s_axis_tlast;
               end
            end
         end
         StPush: begin
            if (pushed) begin
               valid_d  = 1'b0;
               cnt_d    = cnt_q + CNT_W'(1);
               pk_clear = 1'b1;
               if (last_q) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  state_d = StData;
               end
            end
         end
         StDone: begin
            // Only a done that is already visible may be cleared, so a stale
            // processing_done level still lets it show for one cycle.
            if (processing_done && done_q) begin
               done_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      ready_d = (state_d == StIdle) || (state_d == StData);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cmd_q   <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign bus.s_axis_tready     = ready_q;
   assign bus.fifo_write_tvalid = valid_q;
   assign bus.fifo_write_tdata  = pk_block;
   assign aes_cmd               = cmd_q;
   assign axis_slave_done       = done_q;
   assign blk_count             = cnt_q;

endmodule

// File: tb/tb_aes_axis_slave.sv
// Self-checking bench for aes_axis_slave: table of transfers, reset corner
// cases and randomized transfers against a block-level packing model.
`timescale 1ns/1ps
module tb_aes_axis_slave;
   import aes_axis_slave_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        processing_done;
   logic [31:0] aes_cmd;
   logic        axis_slave_done;
   logic [15:0] blk_count;

   aes_axis_slave_if bus ();

   aes_axis_slave dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .aes_cmd         (aes_cmd),
      .axis_slave_done (axis_slave_done),
      .processing_done (processing_done),
      .blk_count       (blk_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int ncyc   = 0;

   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   // FIFO-side responder and push recorder.
   int           stall_cfg  = 0;
   int           stall_left = 0;
   bit           rand_ready = 1'b0;
   logic [127:0] got_q[$];
   int           last_push  = 0;
   logic         pend       = 1'b0;
   logic [127:0] pend_data;
   logic         rdy;

   always @(negedge clk) begin
      if (reset) begin
         bus.fifo_write_tready = 1'b0;
         pend       = 1'b0;
         stall_left = 0;
      end else begin
         if (bus.fifo_write_tvalid && !pend) stall_left = stall_cfg;
         if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end else if (rand_ready) begin
            rdy = ($urandom_range(0, 3) != 0);
         end else begin
            rdy = 1'b1;
         end
         bus.fifo_write_tready = rdy;
         if (pend) begin
            chk("tvalid_hold", bus.fifo_write_tvalid, 1);
            chk("tdata_hold", bus.fifo_write_tdata, pend_data);
         end
         if (bus.fifo_write_tvalid) chk("stream_blocked_in_push", bus.s_axis_tready, 0);
         if (bus.fifo_write_tvalid && rdy) begin
            got_q.push_back(bus.fifo_write_tdata);
            last_push = ncyc;
         end
         pend      = bus.fifo_write_tvalid && !rdy;
         pend_data = bus.fifo_write_tdata;
      end
   end

   // Stream driver: one beat, waits (bounded) for acceptance.
   int accept_cyc = 0;

   task automatic send_beat(input logic [31:0] d, input logic l, input int gap);
      int t;
      for (int i = 0; i < gap; i++) @(negedge clk);
      bus.s_axis_tdata  = d;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tlast  = l;
      t = 0;
      while (!bus.s_axis_tready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) timeout_fail("beat_accept");
      accept_cyc = ncyc;
      @(negedge clk);
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      bus.s_axis_tdata  = $urandom;
   endtask

   // Reference model: beats are chopped into groups of four, first beat in the
   // top word, missing tail words zero.
   logic [127:0] exp_q[$];
   logic [31:0]  words[12];

   function automatic void model(input int n);
      logic [127:0] blk;
      exp_q.delete();
      for (int b = 0; b * 4 < n; b++) begin
         blk = '0;
         for (int j = 0; j < 4; j++)
            if (b * 4 + j < n) blk[127 - 32 * j -: 32] = words[b * 4 + j];
         exp_q.push_back(blk);
      end
   endfunction

   task automatic run_xfer(input logic [31:0] cmd, input int n, input int stall, input bit stale,
                           input bit gaps, input int exp_blocks);
      int t;
      int rise;
      int exp_rise;
      got_q.delete();
      stall_cfg       = stall;
      processing_done = stale;
      model(n);
      send_beat(cmd, (n == 0), gaps ? $urandom_range(0, 2) : 0);
      for (int i = 0; i < n; i++) send_beat(words[i], (i == n - 1), gaps ? $urandom_range(0, 2) : 0);
      if (n > 0) chk("tvalid_latency", bus.fifo_write_tvalid, 1);
      t = 0;
      while (!axis_slave_done && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) begin
         timeout_fail("axis_slave_done");
      end else begin
         rise     = ncyc;
         exp_rise = (n == 0) ? accept_cyc + 1 : last_push + 1;
         chk("done_latency", rise, exp_rise);
         chk("blk_count", blk_count, exp_blocks);
         chk("aes_cmd", aes_cmd, cmd);
         chk("push_count", got_q.size(), exp_q.size());
         if (got_q.size() == exp_q.size())
            for (int i = 0; i < exp_q.size(); i++) chk("block_data", got_q[i], exp_q[i]);
         if (stale) begin
            @(negedge clk);
            chk("done_clear_stale", axis_slave_done, 0);
            chk("idle_ready_stale", bus.s_axis_tready, 1);
         end else begin
            repeat (3) @(negedge clk);
            chk("done_hold", axis_slave_done, 1);
            chk("done_tready_low", bus.s_axis_tready, 0);
            processing_done = 1'b1;
            @(negedge clk);
            chk("done_clear", axis_slave_done, 0);
            chk("idle_ready", bus.s_axis_tready, 1);
            chk("aes_cmd_kept", aes_cmd, cmd);
         end
      end
      processing_done = 1'b0;
      stall_cfg       = 0;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_tready"}, bus.s_axis_tready, 0);
      chk({tag, "_fvalid"}, bus.fifo_write_tvalid, 0);
      chk({tag, "_fdata"}, bus.fifo_write_tdata, 0);
      chk({tag, "_cmd"}, aes_cmd, 0);
      chk({tag, "_done"}, axis_slave_done, 0);
      chk({tag, "_blk_count"}, blk_count, 0);
   endtask

   typedef struct {
      logic [31:0] cmd;
      int          n;
      int          stall;
      bit          stale;
      int          exp_blocks;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{32'h0000_0011, 4, 0, 1'b0, 1};
      vecs[1] = '{32'h0000_0022, 6, 0, 1'b0, 2};
      vecs[2] = '{32'h0000_0033, 0, 0, 1'b0, 0};
      vecs[3] = '{32'h0000_0044, 8, 10, 1'b0, 2};
      vecs[4] = '{32'h0000_0055, 5, 0, 1'b1, 2};
      vecs[5] = '{32'hDEAD_BEEF, 12, 3, 1'b0, 3};

      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      bus.s_axis_tdata  = '0;
      processing_done   = 1'b0;
      reset             = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_values("reset");
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", bus.s_axis_tready, 1);

      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 12; i++) words[i] = $urandom;
         if (v == 0) begin
            words[0] = 32'h0011_2233;
            words[1] = 32'h4455_6677;
            words[2] = 32'h8899_AABB;
            words[3] = 32'hCCDD_EEFF;
         end
         run_xfer(vecs[v].cmd, vecs[v].n, vecs[v].stall, vecs[v].stale, 1'b0, vecs[v].exp_blocks);
         if (v == 0 && got_q.size() > 0)
            chk("first_block_const", got_q[0], 128'h00112233_44556677_8899AABB_CCDDEEFF);
      end

      // Reset after two data beats: partial block discarded.
      got_q.delete();
      send_beat(32'h0000_0077, 1'b0, 0);
      send_beat(32'h1111_1111, 1'b0, 0);
      send_beat(32'h2222_2222, 1'b0, 0);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_values("mid_reset");
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_reset_no_push", got_q.size(), 0);
      words[0] = 32'hA1A1_A1A1;
      words[1] = 32'hB2B2_B2B2;
      words[2] = 32'hC3C3_C3C3;
      words[3] = 32'hD4D4_D4D4;
      run_xfer(32'h0000_0088, 4, 0, 1'b0, 1'b0, 1);

      // Reset while a block waits on a full FIFO: in-flight valid must drop.
      got_q.delete();
      stall_cfg = 50;
      send_beat(32'h0000_0099, 1'b0, 0);
      for (int i = 0; i < 4; i++) send_beat($urandom, 1'b0, 0);
      repeat (3) @(negedge clk);
      chk("stalled_valid", bus.fifo_write_tvalid, 1);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_values("push_reset");
      reset     = 1'b0;
      stall_cfg = 0;
      repeat (3) @(negedge clk);
      chk("push_reset_no_push", got_q.size(), 0);

      // Randomized transfers with random FIFO backpressure and beat gaps.
      rand_ready = 1'b1;
      for (int r = 0; r < 20; r++) begin
         int n;
         n = $urandom_range(0, 11);
         for (int i = 0; i < 12; i++) words[i] = $urandom;
         run_xfer($urandom, n, 0, $urandom_range(0, 1) == 1, 1'b1, (n + 3) / 4);
      end
      rand_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
